sn_operand_receiver: RTL and testbench
======================================

SN_OPERAND_RECEIVER -- requirements
Module: sn_operand_receiver

Interface
REQ-001 SHALL have parameter DATA_W, default 9, operand width in bits.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-high reset (name kept per codebase; high = reset).
REQ-004 SHALL have port ser_in_1  input  1  serial lane for operand 1.
REQ-005 SHALL have port ser_in_2  input  1  serial lane for operand 2, lockstep with lane 1.
REQ-006 SHALL have port window_start  input  1  one-cycle pulse from the stochastic core at clk_counter==0.
REQ-007 SHALL have port operand_1  output  DATA_W  committed operand 1 for the stochastic number generator.
REQ-008 SHALL have port operand_2  output  DATA_W  committed operand 2.
REQ-009 SHALL have port op_update  output  1  one-cycle pulse on the cycle after operands change.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a rejected frame.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when an uncommitted pending pair is overwritten.

Function
REQ-012 Frame per lane: idle 0; start bit 1; DATA_W data bits, LSB first; optional parity bit (REQ-024); stop bit 0; one bit per clk.
REQ-013 FSM states IDLE, DATA, PARITY, STOP; the FSM is shared by both lanes.
REQ-014 IDLE: ser_in_1=1 and ser_in_2=1 -> DATA with bit index 0; ser_in_1=1 and ser_in_2=0 -> frame_err pulse next cycle and stay in IDLE; ser_in_1=0 -> stay in IDLE.
REQ-015 DATA: shift both lanes into their shift registers each cycle; after bit index DATA_W-1 -> PARITY (macro on) or STOP.
REQ-016 STOP: both lanes 0 (and parity good) -> load the pending pair and set pend_full on the next edge; otherwise frame_err pulse with pending unchanged; always -> IDLE.
REQ-017 Completion with pend_full already 1 -> overwrite pending with the newest pair and pulse overrun.
REQ-018 window_start with pend_full=1 -> operand_1/2 take pending values on the next edge, pend_full cleared, op_update pulses the cycle after.
REQ-019 window_start with pend_full=0 -> operands hold, no op_update.
REQ-020 window_start and frame completion on the same cycle -> commit uses the pre-edge pending value; the new pair becomes pending; pend_full stays 1; overrun only if a pending pair was lost uncommitted.
REQ-021 Operands SHALL never change except through REQ-018, so they stay stable across a whole averaging window.

Reset
REQ-022 rst_n high SHALL immediately force: FSM IDLE, bit index 0, shift registers 0, pending 0, pend_full 0, operand_1=0, operand_2=0, op_update=0, frame_err=0, overrun=0.
REQ-023 Reset mid-frame SHALL discard the partial frame; reception restarts with the first start bit after release.

Configuration
REQ-024 Macro SN_RX_PARITY_EN defined: one even-parity bit per lane follows the data bits; a mismatch on either lane -> frame_err, frame discarded; frame length DATA_W+3 cycles.
REQ-025 SN_RX_PARITY_EN undefined: PARITY state and its logic are absent; frame length DATA_W+2 cycles.

Structure
REQ-026 Shared package sn_pkg SHALL hold the FSM state enum, SN_DATA_W=9, and the START/STOP bit constants.
REQ-027 One sub-module sn_lane_shift (per-lane shift register plus parity accumulator) SHALL be instantiated twice; FSM, pending and commit logic stay in the top.

Verification
REQ-028 Frame 9'h0A5 on lane 1 and 9'h13C on lane 2, then window_start -> operand_1=0x0A5, operand_2=0x13C, one op_update pulse.
REQ-029 Lane-1 stop bit driven 1 -> frame_err pulse; a later window_start leaves operands at their previous values.
REQ-030 Two good frames (0x001 then 0x1FF) with no window_start in between -> one overrun pulse; the next window_start commits 0x1FF.
REQ-031 window_start on the same cycle as a STOP of 0x100 -> old pending committed; 0x100 committed at the following window_start.
REQ-032 rst_n pulsed high at data bit 4 -> all outputs 0; the next complete frame 0x055 is received correctly.
REQ-033 SN_RX_PARITY_EN defined with a wrong parity bit on lane 2 -> frame_err, no pending load; with correct parity -> accepted.

Source files
------------

// File: rtl/sn_pkg.sv
// Shared definitions for the stochastic-number operand receiver.
// Optional feature macro: SN_RX_PARITY_EN (adds one even-parity bit per lane).
package sn_pkg;

  // Default operand width fed to the stochastic number generator.
  localparam int SN_DATA_W = 9;

  // Line levels framing each serial operand.
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // Receiver FSM shared by both lanes.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
`ifdef SN_RX_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_STOP   = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sn_lane_shift.sv
// Per-lane deserialiser: LSB-first shift register and, when SN_RX_PARITY_EN
// is defined, a running XOR over data and parity bits (non-zero = bad parity).
module sn_lane_shift
  import sn_pkg::*;
#(
  parameter int DATA_W = SN_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
`ifdef SN_RX_PARITY_EN
  input  logic              acc_clr,
  input  logic              acc_en,
  output logic              par_bad,
`endif
  input  logic              bit_in,
  output logic [DATA_W-1:0] data
);

  // Shift new bits in at the MSB so the first (LSB) bit ends in data[0].
  // NOTE: the shift register is reset as well, so a frame cut by reset leaves no stale bits visible.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      data <= '0;
    end else if (shift_en) begin
      // NOTE: non-blocking assignment keeps every register sampling pre-edge values.
      data <= {bit_in, data[DATA_W-1:1]};
    end
  end

`ifdef SN_RX_PARITY_EN
  logic acc;

  // Even parity: XOR of data bits and the parity bit must be zero.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      acc <= 1'b0;
    end else if (acc_clr) begin
      acc <= 1'b0;
    end else if (acc_en) begin
      acc <= acc ^ bit_in;
    end
  end

  assign par_bad = acc;
`endif

endmodule

// File: rtl/sn_operand_receiver.sv
// Receives two lockstep serial operands, holds the newest good pair as
// pending and commits it to the stochastic number generator only on
// window_start, so operands stay constant across an averaging window.
// Optional feature macro: SN_RX_PARITY_EN (even-parity bit per lane).
module sn_operand_receiver
  import sn_pkg::*;
#(
  parameter int DATA_W = SN_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_in_1,
  input  logic              ser_in_2,
  input  logic              window_start,
  output logic [DATA_W-1:0] operand_1,
  output logic [DATA_W-1:0] operand_2,
  output logic              op_update,
  output logic              frame_err,
  output logic              overrun
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  rx_state_t         state;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift_1;
  logic [DATA_W-1:0] shift_2;
  logic [DATA_W-1:0] pend_1;
  logic [DATA_W-1:0] pend_2;
  logic              pend_full;

  logic shift_en;
  logic stop_bits_ok;
  logic parity_ok;
  logic frame_ok;
  logic frame_bad;

  assign shift_en     = (state == ST_DATA);
  assign stop_bits_ok = (ser_in_1 == STOP_BIT) && (ser_in_2 == STOP_BIT);

`ifdef SN_RX_PARITY_EN
  logic acc_clr;
  logic acc_en;
  logic par_bad_1;
  logic par_bad_2;

  assign acc_clr   = (state == ST_IDLE);
  assign acc_en    = (state == ST_DATA) || (state == ST_PARITY);
  assign parity_ok = !(par_bad_1 || par_bad_2);
`else
  assign parity_ok = 1'b1;
`endif

  // A frame completes in STOP; it is accepted only with clean stop bits and parity.
  assign frame_ok  = (state == ST_STOP) && stop_bits_ok && parity_ok;
  assign frame_bad = (state == ST_STOP) && !(stop_bits_ok && parity_ok);

  sn_lane_shift #(.DATA_W(DATA_W)) u_lane_1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
`ifdef SN_RX_PARITY_EN
    .acc_clr  (acc_clr),
    .acc_en   (acc_en),
    .par_bad  (par_bad_1),
`endif
    .bit_in   (ser_in_1),
    .data     (shift_1)
  );

  sn_lane_shift #(.DATA_W(DATA_W)) u_lane_2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
`ifdef SN_RX_PARITY_EN
    .acc_clr  (acc_clr),
    .acc_en   (acc_en),
    .par_bad  (par_bad_2),
`endif
    .bit_in   (ser_in_2),
    .data     (shift_2)
  );

  // Frame sequencing for both lanes, with a registered frame_err pulse.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= ST_IDLE;
      bit_idx   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ser_in_1 == START_BIT) begin
            if (ser_in_2 == START_BIT) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end else begin
              // Lanes out of lockstep: reject and keep hunting for a start.
              frame_err <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (bit_idx == LAST_IDX) begin
`ifdef SN_RX_PARITY_EN
            state <= ST_PARITY;
`else
            state <= ST_STOP;
`endif
          end else begin
            bit_idx <= bit_idx + 1'b1;
          end
        end
`ifdef SN_RX_PARITY_EN
        ST_PARITY: begin
          state <= ST_STOP;
        end
`endif
        ST_STOP: begin
          state <= ST_IDLE;
          if (frame_bad) begin
            frame_err <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pending pair capture, overrun detection and commit on window_start.
  // The commit reads pre-edge pending values, so a frame landing on the
  // same edge as window_start becomes the next pending pair.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pend_1    <= '0;
      pend_2    <= '0;
      pend_full <= 1'b0;
      operand_1 <= '0;
      operand_2 <= '0;
      op_update <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      op_update <= 1'b0;
      overrun   <= 1'b0;

      if (window_start && pend_full) begin
        operand_1 <= pend_1;
        operand_2 <= pend_2;
        op_update <= 1'b1;
      end

      if (window_start) begin
        pend_full <= 1'b0;
      end

      // A completed frame wins over the clear above: pending stays full.
      if (frame_ok) begin
        pend_1    <= shift_1;
        pend_2    <= shift_2;
        pend_full <= 1'b1;
        // Lost only if the old pair was not committed on this same edge.
        if (pend_full && !window_start) begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sn_operand_receiver.sv
// Directed, table-driven bench for sn_operand_receiver.
// Optional feature macro: SN_RX_PARITY_EN (adds parity vectors).
module tb_sn_operand_receiver;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ser_in_1;
  logic         ser_in_2;
  logic         window_start;
  logic [W-1:0] operand_1;
  logic [W-1:0] operand_2;
  logic         op_update;
  logic         frame_err;
  logic         overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int n_err   = 0;
  int n_ovr   = 0;
  int n_upd   = 0;

  always #5 clk = ~clk;

  sn_operand_receiver #(.DATA_W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ser_in_1     (ser_in_1),
    .ser_in_2     (ser_in_2),
    .window_start (window_start),
    .operand_1    (operand_1),
    .operand_2    (operand_2),
    .op_update    (op_update),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  typedef enum {K_FRAME, K_BADSTART, K_NONE} kind_e;

  typedef struct {
    kind_e        kind;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic         stop1;
    logic         stop2;
    logic         ws;
    int           e_err;
    int           e_ovr;
    int           e_upd;
    logic [W-1:0] e_op1;
    logic [W-1:0] e_op2;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock; pulses are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_err) n_err++;
    if (overrun)   n_ovr++;
    if (op_update) n_upd++;
  endtask

  task automatic clear_counts();
    n_err = 0;
    n_ovr = 0;
    n_upd = 0;
  endtask

  task automatic send_frame(input logic [W-1:0] d1, input logic [W-1:0] d2,
                            input logic p1_flip, input logic p2_flip,
                            input logic stop1, input logic stop2,
                            input logic ws_at_stop);
    ser_in_1 = 1'b1;
    ser_in_2 = 1'b1;
    tick();
    for (int i = 0; i < W; i++) begin
      ser_in_1 = d1[i];
      ser_in_2 = d2[i];
      tick();
    end
`ifdef SN_RX_PARITY_EN
    ser_in_1 = (^d1) ^ p1_flip;
    ser_in_2 = (^d2) ^ p2_flip;
    tick();
`else
    if (p1_flip || p2_flip) $display("note: parity flip ignored in this build");
`endif
    ser_in_1     = stop1;
    ser_in_2     = stop2;
    window_start = ws_at_stop;
    tick();
    ser_in_1     = 1'b0;
    ser_in_2     = 1'b0;
    window_start = 1'b0;
  endtask

  task automatic pulse_window();
    window_start = 1'b1;
    tick();
    window_start = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{K_FRAME,    9'h0A5, 9'h13C, 1'b0, 1'b0, 1'b1, 0, 0, 1, 9'h0A5, 9'h13C};
    vecs[1] = '{K_FRAME,    9'h011, 9'h022, 1'b1, 1'b0, 1'b1, 1, 0, 0, 9'h0A5, 9'h13C};
    vecs[2] = '{K_FRAME,    9'h001, 9'h002, 1'b0, 1'b0, 1'b0, 0, 0, 0, 9'h0A5, 9'h13C};
    vecs[3] = '{K_FRAME,    9'h1FF, 9'h1FE, 1'b0, 1'b0, 1'b0, 0, 1, 0, 9'h0A5, 9'h13C};
    vecs[4] = '{K_NONE,     9'h000, 9'h000, 1'b0, 1'b0, 1'b1, 0, 0, 1, 9'h1FF, 9'h1FE};
    vecs[5] = '{K_NONE,     9'h000, 9'h000, 1'b0, 1'b0, 1'b1, 0, 0, 0, 9'h1FF, 9'h1FE};
    vecs[6] = '{K_BADSTART, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 1, 0, 0, 9'h1FF, 9'h1FE};
    vecs[7] = '{K_FRAME,    9'h0C3, 9'h03C, 1'b0, 1'b1, 1'b1, 1, 0, 0, 9'h1FF, 9'h1FE};
    vecs[8] = '{K_FRAME,    9'h000, 9'h1FF, 1'b0, 1'b0, 1'b1, 0, 0, 1, 9'h000, 9'h1FF};

    rst_n        = 1'b1;
    ser_in_1     = 1'b0;
    ser_in_2     = 1'b0;
    window_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_op1",       operand_1, 0);
    check("reset_op2",       operand_2, 0);
    check("reset_op_update", op_update, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun",   overrun,   0);
    rst_n = 1'b0;
    tick();
    tick();

    // Table-driven vectors
    for (int v = 0; v < 9; v++) begin
      clear_counts();
      case (vecs[v].kind)
        K_FRAME: send_frame(vecs[v].d1, vecs[v].d2, 1'b0, 1'b0,
                            vecs[v].stop1, vecs[v].stop2, 1'b0);
        K_BADSTART: begin
          ser_in_1 = 1'b1;
          ser_in_2 = 1'b0;
          tick();
          ser_in_1 = 1'b0;
          tick();
        end
        default: tick();
      endcase
      if (vecs[v].ws) pulse_window();
      tick();
      check($sformatf("vec%0d_frame_err", v), n_err, vecs[v].e_err);
      check($sformatf("vec%0d_overrun", v),   n_ovr, vecs[v].e_ovr);
      check($sformatf("vec%0d_op_update", v), n_upd, vecs[v].e_upd);
      check($sformatf("vec%0d_op1", v), operand_1, vecs[v].e_op1);
      check($sformatf("vec%0d_op2", v), operand_2, vecs[v].e_op2);
    end

    // window_start on the same cycle as a frame's stop bit
    clear_counts();
    send_frame(9'h0F0, 9'h00F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    send_frame(9'h100, 9'h080, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("same_cycle_op1",     operand_1, 9'h0F0);
    check("same_cycle_op2",     operand_2, 9'h00F);
    check("same_cycle_update",  n_upd, 1);
    check("same_cycle_overrun", n_ovr, 0);
    clear_counts();
    pulse_window();
    check("after_same_op1",    operand_1, 9'h100);
    check("after_same_op2",    operand_2, 9'h080);
    check("after_same_update", n_upd, 1);

    // Reset asserted at data bit 4
    ser_in_1 = 1'b1;
    ser_in_2 = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      ser_in_1 = 1'b1;
      ser_in_2 = i[0];
      tick();
    end
    ser_in_1 = 1'b1;
    ser_in_2 = 1'b1;
    rst_n    = 1'b1;
    #2;
    check("midrst_op1",       operand_1, 0);
    check("midrst_op2",       operand_2, 0);
    check("midrst_op_update", op_update, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_overrun",   overrun,   0);
    @(posedge clk);
    #1;
    ser_in_1 = 1'b0;
    ser_in_2 = 1'b0;
    rst_n    = 1'b0;
    tick();
    clear_counts();
    send_frame(9'h055, 9'h0AA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_window();
    check("postrst_op1",       operand_1, 9'h055);
    check("postrst_op2",       operand_2, 9'h0AA);
    check("postrst_update",    n_upd, 1);
    check("postrst_frame_err", n_err, 0);

`ifdef SN_RX_PARITY_EN
    // Wrong parity on lane 2 is rejected; correct parity is accepted
    clear_counts();
    send_frame(9'h0A5, 9'h13C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_window();
    check("par_bad_err",    n_err, 1);
    check("par_bad_update", n_upd, 0);
    check("par_bad_op1",    operand_1, 9'h055);
    clear_counts();
    send_frame(9'h0A5, 9'h13C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_window();
    check("par_good_err", n_err, 0);
    check("par_good_op1", operand_1, 9'h0A5);
    check("par_good_op2", operand_2, 9'h13C);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
